// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// mul/div occupancy and data-memory wait handling, plus saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = 12;
  localparam logic [WCNT_W-1:0] TIMEOUT_L = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_load_use;
  logic                w_mem_stall;
  logic                w_md_hold;
  logic                w_branch;
  logic                w_lu_stall;

  // Hazard classification in priority order; all terms are forced low in reset
  // so the pipeline enables stay asserted while rst is held.
  always_comb begin
    w_load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));

    w_mem_stall = 1'b0;
    if (!rst) begin
      if (r_state == MEM_WAIT) w_mem_stall = !mem_ack;
      else                     w_mem_stall = mem_req && !mem_ack;
    end

    w_md_hold  = !rst &&
                 (((r_state == RUN) && ex_md_start && !w_mem_stall) ||
                  ((r_state == MD_WAIT) && (!md_done || w_mem_stall)));
    w_branch   = !rst && (r_state == RUN) && !w_mem_stall && !ex_md_start &&
                 ex_branch_taken;
    w_lu_stall = !rst && (r_state == RUN) && !w_mem_stall && !ex_md_start &&
                 !ex_branch_taken && w_load_use;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // A mem stall seen while in MD_WAIT keeps MD_WAIT; md_done in that cycle is dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (w_mem_stall)      w_next = MEM_WAIT;
        else if (ex_md_start) w_next = MD_WAIT;
      end
      MEM_WAIT: if (mem_ack)               w_next = RUN;
      MD_WAIT:  if (md_done && !w_mem_stall) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (w_mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end
    if (w_md_hold) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end
    if (w_branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
    if (w_lu_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // The wait counter saturates at the timeout; mem_err latches on the edge it gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else if ((r_state == MEM_WAIT) && !mem_ack) begin
      if (r_wait_cnt != TIMEOUT_L) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      if (r_wait_cnt >= TIMEOUT_L - WCNT_W'(1)) r_mem_err <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational response table in RUN plus
// hand-written multi-cycle sequences for waits, timeout, counters and reset.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic             ex_md_start, md_done, mem_req, mem_ack, cnt_clr;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_flush, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .md_done(md_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .cnt_clr(cnt_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Output bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_flush
  localparam logic [7:0] O_DEF = 8'b1101_0100;
  localparam logic [7:0] O_LU  = 8'b0001_1100;
  localparam logic [7:0] O_BR  = 8'b1111_1100;
  localparam logic [7:0] O_MEM = 8'b0000_0001;
  localparam logic [7:0] O_MD  = 8'b0000_0110;
  localparam logic [7:0] O_MM  = 8'b0000_0011;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mrd, br, mds, mdd, mreq, mack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_rd = v.rd;
    ex_mem_read = v.mrd; ex_branch_taken = v.br; ex_md_start = v.mds; md_done = v.mdd;
    mem_req = v.mreq; mem_ack = v.mack;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          rs1    rs2    u1 u2 rd     mrd br mds mdd req ack exp
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, O_DEF};
    vecs[1]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, 0, O_LU};
    vecs[2]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 0, 0, O_LU};
    vecs[3]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0, 0, O_DEF};
    vecs[4]  = '{5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, O_DEF};
    vecs[5]  = '{5'd0, 5'd5, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0, O_DEF};
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 0, O_BR};
    vecs[7]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, 0, 0, O_BR};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, O_MEM};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1, O_DEF};
    vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, O_MD};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 1, 0, O_MEM};
    vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 0, 0, O_MD};
    vecs[13] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, O_DEF};
    vecs[14] = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 1, 0, O_MEM};
    vecs[15] = '{5'd4, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, 0, 0, O_LU};

    // Reset: enables stay high even with a memory request pending.
    idle();
    rst = 1'b1;
    mem_req = 1'b1;
    #2;
    chk("reset_outs", 32'(outs()), 32'(O_DEF));
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_count), 0);
    chk("reset_err", 32'(mem_err), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Inputs are withdrawn before the next edge, so state and counters stay put.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      #1;
      idle();
    end

    // Load-use: one stall cycle, then the bubble clears the match.
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1 chk("lu_stall", 32'(outs()), 32'(O_LU));
    @(negedge clk); idle();
    #1 chk("lu_release", 32'(outs()), 32'(O_DEF));
    chk("lu_stall_cnt", 32'(stall_cycles), 1);

    // Branch together with a load-use match: branch response only.
    @(negedge clk);
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1 chk("br_lu", 32'(outs()), 32'(O_BR));
    @(negedge clk); idle();
    #1 chk("br_flush_cnt", 32'(flush_count), 1);
    chk("br_stall_cnt", 32'(stall_cycles), 1);

    // Memory wait: three stall cycles, release on the ack cycle.
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1 chk($sformatf("memw%0d", i), 32'(outs()), 32'(O_MEM));
    end
    @(negedge clk); mem_ack = 1'b1;
    #1 chk("mem_ack_cyc", 32'(outs()), 32'(O_DEF));
    @(negedge clk); idle();
    #1 chk("mem_back_run", 32'(outs()), 32'(O_DEF));
    chk("mem_stall_cnt", 32'(stall_cycles), 3);
    chk("mem_no_err", 32'(mem_err), 0);

    // Mul/div: four occupancy cycles, then md_done releases.
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1 chk($sformatf("md%0d", i), 32'(outs()), 32'(O_MD));
    end
    @(negedge clk); md_done = 1'b1;
    #1 chk("md_done_cyc", 32'(outs()), 32'(O_DEF));
    @(negedge clk); idle();
    #1 chk("md_back_run", 32'(outs()), 32'(O_DEF));
    chk("md_stall_cnt", 32'(stall_cycles), 4);
    @(negedge clk); md_done = 1'b1;
    #1 chk("md_done_in_run", 32'(outs()), 32'(O_DEF));
    @(negedge clk); md_done = 1'b0;
    #1 chk("md_done_ignored", 32'(outs()), 32'(O_DEF));

    // Mem stall inside MD_WAIT: combined outputs, and that md_done is lost.
    @(negedge clk); ex_md_start = 1'b1;
    #1 chk("combo_enter", 32'(outs()), 32'(O_MD));
    @(negedge clk); mem_req = 1'b1; md_done = 1'b1;
    #1 chk("combo_mem_md", 32'(outs()), 32'(O_MM));
    @(negedge clk); mem_ack = 1'b1; md_done = 1'b0; ex_md_start = 1'b0;
    #1 chk("combo_done_lost", 32'(outs()), 32'(O_MD));
    @(negedge clk); mem_req = 1'b0; mem_ack = 1'b0; md_done = 1'b1;
    #1 chk("combo_release", 32'(outs()), 32'(O_DEF));
    @(negedge clk); idle();
    #1 chk("combo_run", 32'(outs()), 32'(O_DEF));

    // Timeout after four unacknowledged MEM_WAIT cycles; stall counter saturates.
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; mem_req = 1'b1;
    #1 chk("to_enter", 32'(outs()), 32'(O_MEM));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("to_wait%0d", i), 32'(mem_err), 0);
    end
    @(negedge clk);
    #1 chk("to_err_set", 32'(mem_err), 1);
    chk("to_still_wait", 32'(outs()), 32'(O_MEM));
    repeat (4) @(negedge clk);
    #1 chk("sat_stall", 32'(stall_cycles), 7);
    chk("to_err_sticky", 32'(mem_err), 1);
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    #1 chk("clr_over_stall", 32'(stall_cycles), 0);

    // Asynchronous reset mid-wait.
    rst = 1'b1;
    #1 chk("rst_err", 32'(mem_err), 0);
    chk("rst_outs", 32'(outs()), 32'(O_DEF));
    @(negedge clk); rst = 1'b0; idle();
    #1 chk("rst_exit_run", 32'(outs()), 32'(O_DEF));
    @(negedge clk);
    #1 chk("rst_run_hold", 32'(outs()), 32'(O_DEF));
    chk("rst_err_clear", 32'(mem_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
